// File: rtl/dp_ram_dma.sv
// Block-move engine on the spare port of the dual-port data RAM.
// Copies (read then write, 2 cycles/word) or fills (1 cycle/word) a word range.
//
// state  | meaning
// IDLE   | waiting for start_i; all RAM outputs 0
// RD     | copy: read source word
// WR     | copy: write the word just read to destination
// FILL   | write latched pattern to destination
// DONE   | one-cycle done_o pulse
module dp_ram_dma #(
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  input  logic [DATA_WIDTH-1:0] fill_data_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH:0]   words_done_o,
  output logic                  en_o,
  output logic                  we_o,
  output logic [NUM_COL-1:0]    be_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  input  logic [DATA_WIDTH-1:0] rdata_i
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_FILL, S_DONE} state_t;

  state_t                state_q, state_d;
  logic                  mode_q;
  logic [ADDR_WIDTH-1:0] src_q, dst_q;
  logic [ADDR_WIDTH:0]   remain_q, words_q;
  logic [DATA_WIDTH-1:0] fill_q;
  logic                  last_word;

  assign last_word    = (remain_q == {{ADDR_WIDTH{1'b0}}, 1'b1});
  assign words_done_o = words_q;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      remain_q <= '0;
      words_q  <= '0;
      fill_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            mode_q   <= mode_i;
            src_q    <= src_addr_i;
            dst_q    <= dst_addr_i;
            remain_q <= len_i;
            fill_q   <= fill_data_i;
            words_q  <= '0;
          end
        end
        // The write in an abort cycle still commits, so it is still counted.
        S_WR: begin
          src_q    <= src_q + 1'b1;
          dst_q    <= dst_q + 1'b1;
          remain_q <= remain_q - 1'b1;
          words_q  <= words_q + 1'b1;
        end
        S_FILL: begin
          dst_q    <= dst_q + 1'b1;
          remain_q <= remain_q - 1'b1;
          words_q  <= words_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    en_o    = 1'b0;
    we_o    = 1'b0;
    be_o    = '0;
    addr_o  = '0;
    wdata_o = '0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_i == '0) state_d = S_DONE;
          else if (mode_i) state_d = S_FILL;
          else             state_d = S_RD;
        end
      end
      S_RD: begin
        busy_o  = 1'b1;
        en_o    = 1'b1;
        addr_o  = src_q;
        state_d = abort_i ? S_IDLE : S_WR;
      end
      S_WR: begin
        busy_o  = 1'b1;
        en_o    = 1'b1;
        we_o    = 1'b1;
        be_o    = {NUM_COL{1'b1}};
        addr_o  = dst_q;
        wdata_o = rdata_i;
        if (abort_i)        state_d = S_IDLE;
        else if (last_word) state_d = S_DONE;
        else                state_d = S_RD;
      end
      S_FILL: begin
        busy_o  = 1'b1;
        en_o    = 1'b1;
        we_o    = 1'b1;
        be_o    = {NUM_COL{1'b1}};
        addr_o  = dst_q;
        wdata_o = fill_q;
        if (abort_i)        state_d = S_IDLE;
        else if (last_word) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // mode_q is captured for completeness; the path taken is fixed at start.
  logic unused_mode;
  assign unused_mode = mode_q;

endmodule
